// File: rtl/tile_rom_arbiter.sv
// rtl/tile_rom_arbiter.sv - shares the tile palette-index ROM between VGA scan-out and game-logic reads
//
// Ports:
//   vga_clk, reset_n          pixel clock, asynchronous active-low reset
//   blank                     1 = active video (display owns the slot), 0 = blanking
//   disp_addr / disp_q        display address in, palette index out (1-cycle latency)
//   logic_req / logic_addr    logic read request and address (sampled on acceptance)
//   logic_ready               request can be accepted this cycle
//   logic_valid / logic_data  one-cycle result pulse and read data
//   rom_address / rom_q       to/from the synchronous-read ROM
//   steal_count               saturating count of display slots given to logic reads
module tile_rom_arbiter #(
    parameter int ADDR_W   = 13,
    parameter int DATA_W   = 6,
    parameter int MAX_WAIT = 64,
    parameter int STEAL_EN = 1
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic              blank,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_q,
    input  logic              logic_req,
    input  logic [ADDR_W-1:0] logic_addr,
    output logic              logic_ready,
    output logic              logic_valid,
    output logic [DATA_W-1:0] logic_data,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [DATA_W-1:0] rom_q,
    output logic [15:0]       steal_count
);

    localparam int WCNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_reg;
    logic [WCNT_W-1:0] wait_cnt;
    logic [DATA_W-1:0] hold_q;
    logic              prev_logic;
    logic              grant;

    // grant depends only on registered state, blank and the wait counter, so
    // there is no combinational path from logic_req to rom_address.
    always_comb begin
        grant       = 1'b0;
        state_nxt   = state;
        logic_ready = (state == IDLE);
        case (state)
            IDLE: begin
                if (logic_req) state_nxt = WAIT;
            end
            WAIT: begin
                grant = !blank || ((STEAL_EN != 0) && (wait_cnt == WAIT_LAST));
                if (grant) state_nxt = DATA;
            end
            DATA: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign rom_address = grant ? addr_reg : disp_addr;

    // The cycle after a logic slot rom_q carries logic data, so the display
    // repeats the last pixel it showed instead.
    assign disp_q = prev_logic ? hold_q : rom_q;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            addr_reg    <= '0;
            wait_cnt    <= '0;
            hold_q      <= '0;
            prev_logic  <= 1'b0;
            logic_valid <= 1'b0;
            logic_data  <= '0;
            steal_count <= '0;
        end else begin
            state       <= state_nxt;
            prev_logic  <= grant;
            logic_valid <= (state == DATA);
            if (state == DATA) logic_data <= rom_q;
            if (!prev_logic) hold_q <= rom_q;

            if (state == IDLE && logic_req) begin
                addr_reg <= logic_addr;
                wait_cnt <= '0;
            end else if (state == WAIT && !grant && wait_cnt != WAIT_LAST) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            if (grant && blank && steal_count != 16'hFFFF) begin
                steal_count <= steal_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_tile_rom_arbiter.sv
// tb/tb_tile_rom_arbiter.sv - directed self-checking bench for tile_rom_arbiter
module tb_tile_rom_arbiter;

    logic        vga_clk = 1'b0;
    logic        reset_n;
    logic        blank;
    logic [12:0] disp_addr;
    logic        logic_req;
    logic [12:0] logic_addr;

    logic [5:0]  disp_q_a, logic_data_a, rom_q_a;
    logic        logic_ready_a, logic_valid_a;
    logic [12:0] rom_address_a;
    logic [15:0] steal_count_a;

    logic [5:0]  disp_q_b, logic_data_b, rom_q_b;
    logic        logic_ready_b, logic_valid_b;
    logic [12:0] rom_address_b;
    logic [15:0] steal_count_b;

    logic [5:0]  mem [0:8191];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 vga_clk = ~vga_clk;

    always @(posedge vga_clk) begin
        rom_q_a <= mem[rom_address_a];
        rom_q_b <= mem[rom_address_b];
    end

    tile_rom_arbiter #(.ADDR_W(13), .DATA_W(6), .MAX_WAIT(64), .STEAL_EN(1)) dut_a (
        .vga_clk(vga_clk), .reset_n(reset_n), .blank(blank), .disp_addr(disp_addr),
        .disp_q(disp_q_a), .logic_req(logic_req), .logic_addr(logic_addr),
        .logic_ready(logic_ready_a), .logic_valid(logic_valid_a), .logic_data(logic_data_a),
        .rom_address(rom_address_a), .rom_q(rom_q_a), .steal_count(steal_count_a)
    );

    tile_rom_arbiter #(.ADDR_W(13), .DATA_W(6), .MAX_WAIT(64), .STEAL_EN(0)) dut_b (
        .vga_clk(vga_clk), .reset_n(reset_n), .blank(blank), .disp_addr(disp_addr),
        .disp_q(disp_q_b), .logic_req(logic_req), .logic_addr(logic_addr),
        .logic_ready(logic_ready_b), .logic_valid(logic_valid_b), .logic_data(logic_data_b),
        .rom_address(rom_address_b), .rom_q(rom_q_b), .steal_count(steal_count_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge vga_clk);
        @(negedge vga_clk);
    endtask

    logic        seen;
    logic [12:0] ra_63, ra_64;
    logic [5:0]  pix_64, pix_65, pix_66, data_66;
    logic        valid_65, valid_66, b_granted, b_ready_seen;

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 6'((i * 5 + 1) % 64);
        mem[13'h123] = 6'h2A;
        mem[13'h010] = 6'h05;

        reset_n = 1'b0; blank = 1'b1; disp_addr = '0; logic_req = 1'b0; logic_addr = '0;
        repeat (2) tick();
        check("rst_ready", 32'(logic_ready_a), 32'd1);
        check("rst_valid", 32'(logic_valid_a), 32'd0);
        check("rst_steal", 32'(steal_count_a), 32'd0);
        check("rst_data", 32'(logic_data_a), 32'd0);
        reset_n = 1'b1;
        tick();

        // reset while a request waits in active video
        logic_req = 1'b1; logic_addr = 13'h055; #1;
        tick();
        logic_req = 1'b0;
        #1 check("wait_not_ready", 32'(logic_ready_a), 32'd0);
        repeat (5) tick();
        disp_addr = 13'h321;
        reset_n = 1'b0;
        #1;
        check("midrst_ready", 32'(logic_ready_a), 32'd1);
        check("midrst_steal", 32'(steal_count_a), 32'd0);
        check("midrst_rom_addr", 32'(rom_address_a), 32'h321);
        tick(); tick();
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (70) begin
            tick();
            seen = seen | logic_valid_a | logic_valid_b;
        end
        check("midrst_no_valid", 32'(seen), 32'd0);
        check("midrst_no_steal", 32'(steal_count_a), 32'd0);

        // read during blanking
        blank = 1'b0; logic_addr = 13'h123; logic_req = 1'b1; #1;
        check("blk_ready", 32'(logic_ready_a), 32'd1);
        tick();
        logic_req = 1'b0; logic_addr = 13'h1FFF; #1;
        check("blk_grant_addr", 32'(rom_address_a), 32'h123);
        check("blk_valid_early", 32'(logic_valid_a), 32'd0);
        tick(); #1;
        check("blk_data_cycle_addr", 32'(rom_address_a), 32'h321);
        tick(); #1;
        check("blk_valid", 32'(logic_valid_a), 32'd1);
        check("blk_data", 32'(logic_data_a), 32'h2A);
        check("blk_data_b", 32'(logic_data_b), 32'h2A);
        tick(); #1;
        check("blk_valid_once", 32'(logic_valid_a), 32'd0);
        check("blk_no_steal", 32'(steal_count_a), 32'd0);

        // back-to-back: second request presented while logic_valid is high
        logic_addr = 13'h010; logic_req = 1'b1;
        tick();
        logic_req = 1'b0;
        tick(); tick(); #1;
        check("b2b_valid1", 32'(logic_valid_a), 32'd1);
        check("b2b_data1", 32'(logic_data_a), 32'h05);
        logic_req = 1'b1; logic_addr = 13'h123; #1;
        check("b2b_ready_in_valid", 32'(logic_ready_a), 32'd1);
        tick();
        logic_req = 1'b0; #1;
        check("b2b_grant_addr", 32'(rom_address_a), 32'h123);
        check("b2b_valid_gap", 32'(logic_valid_a), 32'd0);
        tick(); tick(); #1;
        check("b2b_valid2", 32'(logic_valid_a), 32'd1);
        check("b2b_data2", 32'(logic_data_a), 32'h2A);
        tick();

        // continuous active video: dut_a steals after 64 WAIT cycles, dut_b waits
        blank = 1'b1; disp_addr = 13'h100; logic_addr = 13'h010; logic_req = 1'b1;
        tick();
        logic_req = 1'b0;
        ra_63 = '0; ra_64 = '0; pix_64 = '0; pix_65 = '0; pix_66 = '0; data_66 = '0;
        valid_65 = 1'b1; valid_66 = 1'b0; b_granted = 1'b0; b_ready_seen = 1'b0;
        for (int i = 1; i <= 1000; i++) begin
            disp_addr = 13'h100 + 13'(i % 256);
            #1;
            if (i == 63) ra_63 = rom_address_a;
            if (i == 64) begin ra_64 = rom_address_a; pix_64 = disp_q_a; end
            if (i == 65) begin pix_65 = disp_q_a; valid_65 = logic_valid_a; end
            if (i == 66) begin pix_66 = disp_q_a; valid_66 = logic_valid_a; data_66 = logic_data_a; end
            if (rom_address_b == 13'h010) b_granted = 1'b1;
            if (logic_ready_b) b_ready_seen = 1'b1;
            tick();
        end
        check("steal_no_grant_63", 32'(ra_63), 32'h13F);
        check("steal_grant_64", 32'(ra_64), 32'h010);
        check("steal_pix_grant", 32'(pix_64), 32'(mem[13'h13F]));
        check("steal_pix_repeat", 32'(pix_65), 32'(mem[13'h13F]));
        check("steal_valid_not_65", 32'(valid_65), 32'd0);
        check("steal_valid_66", 32'(valid_66), 32'd1);
        check("steal_data", 32'(data_66), 32'h05);
        check("steal_pix_resume", 32'(pix_66), 32'(mem[13'h141]));
        check("steal_count_a", 32'(steal_count_a), 32'd1);
        check("nosteal_no_grant", 32'(b_granted), 32'd0);
        check("nosteal_not_ready", 32'(b_ready_seen), 32'd0);
        blank = 1'b0; disp_addr = 13'h200; #1;
        check("nosteal_grant_blank", 32'(rom_address_b), 32'h010);
        tick(); tick(); #1;
        check("nosteal_valid", 32'(logic_valid_b), 32'd1);
        check("nosteal_data", 32'(logic_data_b), 32'h05);
        check("nosteal_count", 32'(steal_count_b), 32'd0);
        tick();

        // display sweep without logic traffic
        blank = 1'b1;
        for (int k = 0; k <= 48; k++) begin
            if (k < 48) disp_addr = 13'(k);
            #1;
            if (k > 0) check($sformatf("disp_sweep_%0d", k - 1), 32'(disp_q_a), 32'(mem[k - 1]));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
